// File: rtl/camera_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : camera_ctrl
// Purpose  : Capture sequencer for the pixel array. It runs exposure/readout
//            through the timer and owns the user exposure-time setting.
// Option   : define CAMERA_CTRL_BTN_SYNC_EN to add 2-flop button synchronizers
// Revision : 1.0 - initial release
// ============================================================================
module camera_ctrl #(
    parameter int EXP_W     = 5,
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,
    parameter int EXP_RESET = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exposure,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Ovf5,
    input  logic             Ovf4,
    output logic             Initial,
    output logic             Start,
    output logic [EXP_W-1:0] Exp_time,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC,
    output logic             Busy
);

    localparam logic [EXP_W-1:0] c_exp_min   = EXP_MIN[EXP_W-1:0];
    localparam logic [EXP_W-1:0] c_exp_max   = EXP_MAX[EXP_W-1:0];
    localparam logic [EXP_W-1:0] c_exp_reset = EXP_RESET[EXP_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXP_LOAD = 3'd1,
        S_EXPOSE   = 3'd2,
        S_RD_LOAD  = 3'd3,
        S_READ     = 3'd4
    } state_t;

    logic w_init, w_exp, w_inc, w_dec;

`ifdef CAMERA_CTRL_BTN_SYNC_EN
    logic [3:0] r_sync1_q, r_sync2_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1_q <= 4'b0000;
            r_sync2_q <= 4'b0000;
        end else begin
            r_sync1_q <= {Init, Exposure, Exp_increase, Exp_decrease};
            r_sync2_q <= r_sync1_q;
        end
    end

    assign {w_init, w_exp, w_inc, w_dec} = r_sync2_q;
`else
    assign {w_init, w_exp, w_inc, w_dec} = {Init, Exposure, Exp_increase, Exp_decrease};
`endif

    logic r_exp_prev_q, r_inc_prev_q, r_dec_prev_q;
    logic w_rise_exp, w_rise_inc, w_rise_dec;

    assign w_rise_exp = w_exp & ~r_exp_prev_q;
    assign w_rise_inc = w_inc & ~r_inc_prev_q;
    assign w_rise_dec = w_dec & ~r_dec_prev_q;

    state_t           r_state_q, w_state_d;
    logic [2:0]       r_step_q, w_step_d;
    logic [EXP_W-1:0] r_exp_time_q, w_exp_time_d;
    logic r_initial_q, r_start_q, r_erase_q, r_expose_q;
    logic r_nre1_q, r_nre2_q, r_adc_q, r_busy_q;
    logic w_initial_d, w_start_d, w_erase_d, w_expose_d;
    logic w_nre1_d, w_nre2_d, w_adc_d, w_busy_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_step_d     = r_step_q;
        w_exp_time_d = r_exp_time_q;

        if (w_init) begin
            w_state_d = S_IDLE;
            w_step_d  = 3'd0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_rise_exp)
                        w_state_d = S_EXP_LOAD;
                    // simultaneous increase and decrease cancel out
                    if (w_rise_inc && !w_rise_dec && r_exp_time_q < c_exp_max)
                        w_exp_time_d = r_exp_time_q + 1'b1;
                    else if (w_rise_dec && !w_rise_inc && r_exp_time_q > c_exp_min)
                        w_exp_time_d = r_exp_time_q - 1'b1;
                end
                S_EXP_LOAD: w_state_d = S_EXPOSE;
                S_EXPOSE: begin
                    if (Ovf5)
                        w_state_d = S_RD_LOAD;
                end
                S_RD_LOAD: begin
                    w_state_d = S_READ;
                    w_step_d  = 3'd0;
                end
                S_READ: begin
                    if (Ovf4) begin
                        if (r_step_q == 3'd7) begin
                            w_state_d = S_IDLE;
                            w_step_d  = 3'd0;
                        end else begin
                            w_step_d = r_step_q + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                    w_step_d  = 3'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_erase_d   = (w_state_d == S_IDLE);
        w_expose_d  = (w_state_d == S_EXP_LOAD) || (w_state_d == S_EXPOSE);
        w_initial_d = (w_state_d == S_EXP_LOAD) || (w_state_d == S_RD_LOAD);
        w_start_d   = (w_state_d == S_EXPOSE)   || (w_state_d == S_READ);
        w_busy_d    = (w_state_d != S_IDLE);
        w_nre1_d    = 1'b1;
        w_nre2_d    = 1'b1;
        w_adc_d     = 1'b0;
        if (w_state_d == S_READ) begin
            case (w_step_d)
                3'd0, 3'd2: w_nre1_d = 1'b0;
                3'd1: begin
                    w_nre1_d = 1'b0;
                    w_adc_d  = 1'b1;
                end
                3'd4, 3'd6: w_nre2_d = 1'b0;
                3'd5: begin
                    w_nre2_d = 1'b0;
                    w_adc_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q    <= S_IDLE;
            r_step_q     <= 3'd0;
            r_exp_time_q <= c_exp_reset;
            r_exp_prev_q <= 1'b0;
            r_inc_prev_q <= 1'b0;
            r_dec_prev_q <= 1'b0;
            r_initial_q  <= 1'b0;
            r_start_q    <= 1'b0;
            r_erase_q    <= 1'b1;
            r_expose_q   <= 1'b0;
            r_nre1_q     <= 1'b1;
            r_nre2_q     <= 1'b1;
            r_adc_q      <= 1'b0;
            r_busy_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_step_q     <= w_step_d;
            r_exp_time_q <= w_exp_time_d;
            r_exp_prev_q <= w_exp;
            r_inc_prev_q <= w_inc;
            r_dec_prev_q <= w_dec;
            r_initial_q  <= w_initial_d;
            r_start_q    <= w_start_d;
            r_erase_q    <= w_erase_d;
            r_expose_q   <= w_expose_d;
            r_nre1_q     <= w_nre1_d;
            r_nre2_q     <= w_nre2_d;
            r_adc_q      <= w_adc_d;
            r_busy_q     <= w_busy_d;
        end
    end

    assign Initial  = r_initial_q;
    assign Start    = r_start_q;
    assign Exp_time = r_exp_time_q;
    assign Erase    = r_erase_q;
    assign Expose   = r_expose_q;
    assign NRE_1    = r_nre1_q;
    assign NRE_2    = r_nre2_q;
    assign ADC      = r_adc_q;
    assign Busy     = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_ctrl
// Purpose  : Randomised scoreboard bench for camera_ctrl against a phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_ctrl;

    logic       clk = 1'b0;
    logic       rst, init, expo, inc, dec, ovf5, ovf4;
    logic       initial_o, start_o, erase_o, expose_o, nre1_o, nre2_o, adc_o, busy_o;
    logic [4:0] exp_time_o;

    always #5 clk = ~clk;

    camera_ctrl dut (
        .Clk          (clk),
        .Reset        (rst),
        .Init         (init),
        .Exposure     (expo),
        .Exp_increase (inc),
        .Exp_decrease (dec),
        .Ovf5         (ovf5),
        .Ovf4         (ovf4),
        .Initial      (initial_o),
        .Start        (start_o),
        .Exp_time     (exp_time_o),
        .Erase        (erase_o),
        .Expose       (expose_o),
        .NRE_1        (nre1_o),
        .NRE_2        (nre2_o),
        .ADC          (adc_o),
        .Busy         (busy_o)
    );

    // Model phases: 0 idle, 1 exposure load, 2 exposing, 3 readout load, 4 reading
    int         m_phase = 0;
    int         m_step  = 0;
    int         m_exp   = 15;
    bit         m_pe, m_pi, m_pd;
    bit [3:0]   m_h1, m_h2;
    logic [12:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    function automatic logic [12:0] expect_vec();
        bit rd;
        int row, sub;
        bit n1, n2, adc_e;
        rd    = (m_phase == 4);
        row   = m_step / 4;
        sub   = m_step % 4;
        n1    = !(rd && row == 0 && sub < 3);
        n2    = !(rd && row == 1 && sub < 3);
        adc_e = rd && sub == 1;
        return {(m_phase == 1 || m_phase == 3), (m_phase == 2 || m_phase == 4),
                5'(m_exp), (m_phase == 0), (m_phase == 1 || m_phase == 2),
                n1, n2, adc_e, (m_phase != 0)};
    endfunction

    task automatic drive(input bit r, input bit i, input bit e, input bit up,
                         input bit dn, input bit o5, input bit o4);
        bit [3:0] eff;
        bit re, ru, rdn;
        rst = r; init = i; expo = e; inc = up; dec = dn; ovf5 = o5; ovf4 = o4;
        if (r) begin
            m_phase = 0; m_step = 0; m_exp = 15;
            m_pe = 0; m_pi = 0; m_pd = 0; m_h1 = 0; m_h2 = 0;
        end else begin
`ifdef CAMERA_CTRL_BTN_SYNC_EN
            eff  = m_h2;
            m_h2 = m_h1;
            m_h1 = {i, e, up, dn};
`else
            eff = {i, e, up, dn};
`endif
            re  = eff[2] && !m_pe;
            ru  = eff[1] && !m_pi;
            rdn = eff[0] && !m_pd;
            if (eff[3]) begin
                m_phase = 0; m_step = 0;
            end else if (m_phase == 0) begin
                if (ru && !rdn) m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
                if (rdn && !ru) m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
                if (re) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (o5) m_phase = 3;
            end else if (m_phase == 3) begin
                m_phase = 4; m_step = 0;
            end else if (o4) begin
                m_step = m_step + 1;
                if (m_step == 8) begin
                    m_phase = 0; m_step = 0;
                end
            end
            m_pe = eff[2]; m_pi = eff[1]; m_pd = eff[0];
        end
        exp_q.push_back(expect_vec());
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [12:0] act, req;
        cyc++;
        if (exp_q.size() > 0) begin
            req = exp_q.pop_front();
            act = {initial_o, start_o, exp_time_o, erase_o, expose_o, nre1_o, nre2_o, adc_o, busy_o};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL outputs cyc=%0d [Initial,Start,Exp_time,Erase,Expose,NRE_1,NRE_2,ADC,Busy] act=%b,%b,%0d,%b,%b,%b,%b,%b,%b req=%b,%b,%0d,%b,%b,%b,%b,%b,%b",
                         cyc, act[12], act[11], act[10:6], act[5], act[4], act[3], act[2], act[1], act[0],
                         req[12], req[11], req[10:6], req[5], req[4], req[3], req[2], req[1], req[0]);
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // abort: 0 none, 1 Init at read step 5, 2 Reset while exposing
    task automatic run_capture(input int o5_delay, input int o4_per, input bit noisy,
                               input int abort, input bit with_inc);
        drive(0, 0, 1, with_inc, 0, 0, 0);
        for (int c = 1; c < 200; c++) begin
            bit o5, o4, e, up, dn, i, r;
            o5 = (c == o5_delay);
            o4 = (c % o4_per == 0);
            e = 0; up = 0; dn = 0; i = 0; r = 0;
            if (noisy) begin
                e  = 1'($urandom % 2);
                up = 1'($urandom % 2);
                dn = 1'($urandom % 2);
                if (!o5) o5 = ($urandom % 8 == 0);
            end
            if (abort == 1 && m_phase == 4 && m_step == 5) i = 1;
            if (abort == 2 && m_phase == 2) r = 1;
            drive(r, i, e, up, dn, o5, o4);
            if (i || r) break;
            if (m_phase == 0 && c > 2) break;
        end
        idle(3);
    endtask

    initial begin
        rst = 1; init = 0; expo = 0; inc = 0; dec = 0; ovf5 = 0; ovf4 = 0;
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int k = 0; k < 20; k++) begin drive(0, 0, 0, 1, 0, 0, 0); idle(1); end
        for (int k = 0; k < 40; k++) begin drive(0, 0, 0, 0, 1, 0, 0); idle(1); end
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 1, 0, 0);
        idle(2);
        drive(0, 0, 0, 1, 1, 0, 0);
        idle(3);

        run_capture(10, 4, 0, 0, 0);
        run_capture(12, 4, 1, 0, 0);
        run_capture(11, 3, 0, 0, 1);
        run_capture(10, 4, 0, 1, 0);
        run_capture(10, 4, 0, 2, 0);
        for (int k = 0; k < 8; k++)
            run_capture($urandom_range(4, 15), $urandom_range(1, 5), 1'($urandom % 2),
                        0, 1'($urandom % 2));

        for (int k = 0; k < 2000; k++)
            drive($urandom % 200 == 0, $urandom % 60 == 0, $urandom % 6 == 0,
                  $urandom % 6 == 0, $urandom % 6 == 0, $urandom % 3 == 0, $urandom % 3 == 0);
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d pending req=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/camera_ctrl.md
Name: camera_ctrl

Overview:
Main control FSM of the digital camera. It drives the exposure/readout timer through Initial and Start, and consumes the timer's Ovf5 (exposure elapsed) and Ovf4 (readout sub-step elapsed). It owns the user exposure-time register and generates the pixel-array control strobes: Erase, Expose, NRE_1, NRE_2 and ADC.

Parameters:
EXP_W, 5, width of the exposure-time register and the Exp_time port
EXP_MIN, 2, lower saturation bound of the exposure time
EXP_MAX, 30, upper saturation bound of the exposure time
EXP_RESET, 15, exposure-time value loaded by Reset

Ports:
Clk  input  1  system clock; all logic on the rising edge
Reset  input  1  synchronous, active-high; full reset, including the exposure register
Init  input  1  button; synchronous return to IDLE; exposure register kept
Exposure  input  1  button; rising edge starts a capture
Exp_increase  input  1  button; rising edge increments the exposure time
Exp_decrease  input  1  button; rising edge decrements the exposure time
Ovf5  input  1  from timer: exposure time elapsed
Ovf4  input  1  from timer: readout sub-step elapsed
Initial  output  1  to timer: load Exp_time / clear count, one cycle
Start  output  1  to timer: count enable
Exp_time  output  EXP_W  current exposure setting, loaded by the timer on Initial
Erase  output  1  pixel erase, active-high
Expose  output  1  pixel exposure, active-high
NRE_1  output  1  row 1 read enable, active-low
NRE_2  output  1  row 2 read enable, active-low
ADC  output  1  ADC convert strobe, active-high
Busy  output  1  high in any state other than IDLE

Behaviour:
- Single clock domain: Clk. Reset is synchronous and active-high. Outputs are a Moore decode of registered state; no input-to-output combinational path.
- Edge detect: one register per button holds the previous sample. A rise is input=1 while the stored sample is 0. Every edge register clears to 0 on Reset.
- States: IDLE, EXP_LOAD, EXPOSE, RD_LOAD, READ. READ carries a 3-bit step counter, step = 0..7.
- Reset values: state IDLE, step 0, Exp_time = EXP_RESET, Erase=1, NRE_1=NRE_2=1, Expose=ADC=Initial=Start=Busy=0.
- IDLE:
  - Outputs: Erase=1, everything else inactive.
  - Rise on Exposure -> EXP_LOAD on the next edge.
  - Rise on Exp_increase: Exp_time+1, saturating at EXP_MAX.
  - Rise on Exp_decrease: Exp_time-1, saturating at EXP_MIN.
  - Both rises in the same cycle: no change.
  - Exposure rise together with an increase/decrease rise: the exposure starts, and Exp_time still updates in the same cycle.
- EXP_LOAD (1 cycle): Expose=1, Initial=1, Start=0 -> EXPOSE.
- EXPOSE: Expose=1, Start=1. On Ovf5=1 -> RD_LOAD.
- RD_LOAD (1 cycle): Initial=1, Start=0, all strobes inactive -> READ with step=0.
- READ: Start=1. Step advances on each cycle with Ovf4=1. Step decode:
  - step 0: NRE_1=0
  - step 1: NRE_1=0, ADC=1
  - step 2: NRE_1=0
  - step 3: all inactive
  - step 4: NRE_2=0
  - step 5: NRE_2=0, ADC=1
  - step 6: NRE_2=0
  - step 7: all inactive
  - Ovf4 at step 7 -> IDLE, step cleared to 0.
- Ovf5 is ignored outside EXPOSE. Ovf4 is ignored outside READ.
- Exposure, Exp_increase and Exp_decrease are ignored outside IDLE. Their edge registers keep sampling, so a button held through a capture does not retrigger.
- Exp_time is stable in all states other than IDLE.
- Init=1 in any state -> IDLE on the next edge, step cleared. Init takes priority over all other transitions and over button actions in that cycle. Exp_time is unchanged by Init.
- Reset takes priority over Init. Reset mid-capture aborts immediately to the reset values.
- Capture latency: Exposure rise sampled at edge N -> Initial high in cycle N+1 -> Start high from N+2.

Optional Feature:
- Macro CAMERA_CTRL_BTN_SYNC_EN.
- Defined: Init, Exposure, Exp_increase and Exp_decrease each pass through a 2-flop synchronizer, reset to 0, before edge detection and FSM use. All button-to-response latencies grow by 2 cycles. Ovf4/Ovf5 are not synchronized.
- Undefined: buttons are used directly and latencies are as stated in Behaviour.

Test Plan:
- Reset, hold 3 cycles -> IDLE, Exp_time=15, Erase=1, NRE_1=NRE_2=1, Busy=0, Initial=Start=0.
- 20 Exp_increase pulses, then 40 Exp_decrease pulses -> Exp_time saturates at 30, then at 2. A single held-high press changes it by 1 only.
- Exposure rise at edge N; Ovf5 pulsed 10 cycles later; Ovf4 pulsed every 4 cycles ->
  - Initial=1 at N+1; Start from N+2; Expose=1 in N+1 through the Ovf5 cycle.
  - Then RD_LOAD, then the NRE_1/ADC/NRE_2 sequence over steps 0..7 matching the decode table; ADC high exactly twice.
  - Return to IDLE with Erase=1.
- Spurious Ovf4 during EXPOSE and Ovf5 during READ; Exposure rise during READ -> no state change, no retrigger, step count unaffected.
- Init asserted at READ step 5 -> IDLE next edge, NRE_2=1, ADC=0, Exp_time unchanged. Reset asserted during EXPOSE -> all reset values next edge, Exp_time=15.
- With CAMERA_CTRL_BTN_SYNC_EN defined, repeat the capture test -> Initial appears at N+3.
